// File: rtl/clk_en_sequencer.sv
// Clock-enable sequencer: ce strobe and divided square wave at one of up to four
// divide ratios. Rate changes wait for the end of the current period, so no runt periods.
//
// state      | meaning
// ST_STEADY  | running in mode_q, no switch queued
// ST_PENDING | next_mode_q queued, applied at the next period boundary
module clk_en_sequencer #(
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned DWELL     = 256,
  parameter int unsigned DIV0      = 50,
  parameter int unsigned DIV1      = 10,
  parameter int unsigned DIV2      = 2,
  parameter int unsigned DIV3      = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       auto_en,
  input  logic       sel_valid,
  input  logic [1:0] sel_mode,
  output logic       sel_ready,
  output logic [1:0] mode_o,
  output logic       ce_o,
  output logic       clk_div_o,
  output logic       mode_chg_o,
  output logic       sel_err_o
);

  localparam int unsigned W1 = CNT_W + 1;

  typedef enum logic {ST_STEADY = 1'b0, ST_PENDING = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         next_mode_q, next_mode_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic               ce_q, ce_d;
  logic               mode_chg_q, mode_chg_d;
  logic               sel_err_q, sel_err_d;

  logic [W1-1:0]      div_len;
  logic [W1-1:0]      half_len;
  logic               div_last;
  logic               dwell_last;
  logic               expire;
  logic               mode_ok;
  logic [1:0]         auto_next;

  always_comb begin
    case (mode_q)
      2'd0:    div_len = W1'(DIV0);
      2'd1:    div_len = W1'(DIV1);
      2'd2:    div_len = W1'(DIV2);
      default: div_len = W1'(DIV3);
    endcase
  end

  // Widened by one bit so DIV = 2^CNT_W still compares correctly.
  assign half_len   = (div_len + W1'(1)) >> 1;
  assign div_last   = ({1'b0, div_cnt_q} == (div_len - W1'(1)));
  assign dwell_last = ({1'b0, dwell_cnt_q} == W1'(DWELL - 1));
  assign expire     = (state_q == ST_STEADY) && dwell_last;
  assign mode_ok    = ({1'b0, sel_mode} < 3'(NUM_MODES));
  assign auto_next  = (mode_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    next_mode_d = next_mode_q;
    div_cnt_d   = div_last ? '0 : div_cnt_q + CNT_W'(1);
    dwell_cnt_d = dwell_cnt_q;
    ce_d        = div_last;
    mode_chg_d  = 1'b0;
    sel_err_d   = 1'b0;
    sel_ready   = 1'b0;
    case (state_q)
      ST_STEADY: begin
        // A dwell expiry wins even if auto_en dropped in the same cycle.
        if (expire) begin
          state_d     = ST_PENDING;
          next_mode_d = auto_next;
        end else if (auto_en) begin
          dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
        end else begin
          dwell_cnt_d = '0;
          sel_ready   = 1'b1;
          if (sel_valid) begin
            if (mode_ok) begin
              state_d     = ST_PENDING;
              next_mode_d = sel_mode;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
      end
      ST_PENDING: begin
        if (div_last) begin
          state_d     = ST_STEADY;
          mode_d      = next_mode_q;
          div_cnt_d   = '0;
          dwell_cnt_d = '0;
          mode_chg_d  = 1'b1;
        end
      end
      default: state_d = ST_STEADY;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_STEADY;
      mode_q      <= 2'd0;
      next_mode_q <= 2'd0;
      div_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      ce_q        <= 1'b0;
      mode_chg_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      next_mode_q <= next_mode_d;
      div_cnt_q   <= div_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      ce_q        <= ce_d;
      mode_chg_q  <= mode_chg_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign mode_o     = mode_q;
  assign ce_o       = ce_q;
  assign clk_div_o  = ({1'b0, div_cnt_q} < half_len);
  assign mode_chg_o = mode_chg_q;
  assign sel_err_o  = sel_err_q;

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Bench for clk_en_sequencer: two instances (4 modes and 3 modes) share stimulus and are
// checked every cycle against a behavioural model, plus hand-computed literal points.
module tb_clk_en_sequencer;

  localparam int DWELL = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       auto_en   = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_mode  = 2'd0;

  logic       rdy_w  [2];
  logic [1:0] mode_w [2];
  logic       ce_w   [2];
  logic       cdiv_w [2];
  logic       chg_w  [2];
  logic       err_w  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    int mode;
    int pos;
    int dwell;
    int pend;
    int nxt;
    int ce;
    int chg;
    int err;
  } mstate_t;

  mstate_t m [2];
  int      nmodes [2] = '{4, 3};

  clk_en_sequencer #(.NUM_MODES(4), .DWELL(DWELL), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(1),
                     .CNT_W(16)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .auto_en(auto_en), .sel_valid(sel_valid),
    .sel_mode(sel_mode), .sel_ready(rdy_w[0]), .mode_o(mode_w[0]), .ce_o(ce_w[0]),
    .clk_div_o(cdiv_w[0]), .mode_chg_o(chg_w[0]), .sel_err_o(err_w[0]));

  clk_en_sequencer #(.NUM_MODES(3), .DWELL(DWELL), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(1),
                     .CNT_W(16)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .auto_en(auto_en), .sel_valid(sel_valid),
    .sel_mode(sel_mode), .sel_ready(rdy_w[1]), .mode_o(mode_w[1]), .ce_o(ce_w[1]),
    .clk_div_o(cdiv_w[1]), .mode_chg_o(chg_w[1]), .sel_err_o(err_w[1]));

  always #5 sys_clk = ~sys_clk;

  function automatic int divof(int md);
    case (md)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Position within the current period and dwell time are tracked as plain integers.
  function automatic mstate_t step(mstate_t s, int nm, logic au, logic sv, logic [1:0] sm);
    mstate_t n;
    int      div;
    bit      last;
    bit      exp_now;
    n       = s;
    div     = divof(s.mode);
    last    = (s.pos == div - 1);
    exp_now = (s.pend == 0) && (s.dwell == DWELL - 1);
    n.ce    = last ? 1 : 0;
    n.chg   = 0;
    n.err   = 0;
    if (s.pend != 0 && last) begin
      n.mode  = s.nxt;
      n.pos   = 0;
      n.dwell = 0;
      n.pend  = 0;
      n.chg   = 1;
    end else begin
      n.pos = last ? 0 : s.pos + 1;
      if (s.pend == 0) begin
        if (exp_now) begin
          n.pend = 1;
          n.nxt  = (s.mode + 1) % nm;
        end else if (au) begin
          n.dwell = s.dwell + 1;
        end else begin
          n.dwell = 0;
          if (sv) begin
            if (int'(sm) < nm) begin
              n.pend = 1;
              n.nxt  = int'(sm);
            end else begin
              n.err = 1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic int exp_ready(mstate_t s, logic au);
    return (!au && s.pend == 0 && s.dwell != DWELL - 1) ? 1 : 0;
  endfunction

  function automatic int exp_cdiv(mstate_t s);
    return (s.pos < (divof(s.mode) + 1) / 2) ? 1 : 0;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc  <= 0;
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      cyc  <= cyc + 1;
      m[0] <= step(m[0], nmodes[0], auto_en, sel_valid, sel_mode);
      m[1] <= step(m[1], nmodes[1], auto_en, sel_valid, sel_mode);
    end
  end

  always @(negedge sys_clk) begin
    #2;
    if (sys_rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("mdl_mode%0d", d),  int'(mode_w[d]), m[d].mode);
        chk($sformatf("mdl_ce%0d", d),    int'(ce_w[d]),   m[d].ce);
        chk($sformatf("mdl_chg%0d", d),   int'(chg_w[d]),  m[d].chg);
        chk($sformatf("mdl_err%0d", d),   int'(err_w[d]),  m[d].err);
        chk($sformatf("mdl_cdiv%0d", d),  int'(cdiv_w[d]), exp_cdiv(m[d]));
        chk($sformatf("mdl_ready%0d", d), int'(rdy_w[d]),  exp_ready(m[d], auto_en));
      end
    end
  end

  task automatic at(int n);
    while (cyc < n) @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset(logic au);
    sys_rst_n = 1'b0;
    sel_valid = 1'b0;
    sel_mode  = 2'd0;
    auto_en   = au;
    #7;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg_cnt;

    // Auto cycling from reset: 0 -> 1 -> 2 -> 3 -> 0.
    do_reset(1'b1);
    at(0);  chk("cdiv_c0", int'(cdiv_w[0]), 1);
    at(1);  chk("cdiv_c1", int'(cdiv_w[0]), 1);
    at(2);  chk("cdiv_c2", int'(cdiv_w[0]), 0);
    at(3);  chk("cdiv_c3", int'(cdiv_w[0]), 0); chk("ce_c3", int'(ce_w[0]), 0);
    at(4);  chk("ce_c4", int'(ce_w[0]), 1);
    at(19); chk("mode_c19", int'(mode_w[0]), 0);
    at(20); chk("mode_c20", int'(mode_w[0]), 1); chk("chg_c20", int'(chg_w[0]), 1);
    at(38); chk("mode_c38", int'(mode_w[0]), 2);
    at(56); chk("mode_c56", int'(mode_w[0]), 3);
    at(60); chk("ce_div1", int'(ce_w[0]), 1);
    at(72); chk("mode_c72", int'(mode_w[0]), 3);
    at(73); chk("mode_wrap", int'(mode_w[0]), 0);
    at(100);

    // Manual request mid-period, then an out-of-range request on the 3-mode instance.
    do_reset(1'b0);
    at(1);  chk("rdy_c1", int'(rdy_w[0]), 1); sel_valid = 1'b1; sel_mode = 2'd2;
    at(2);  chk("rdy_c2", int'(rdy_w[0]), 0); sel_valid = 1'b0;
    at(3);  chk("man_mode_c3", int'(mode_w[0]), 0);
    at(4);  chk("man_mode_c4", int'(mode_w[0]), 2); chk("man_chg_c4", int'(chg_w[0]), 1);
    at(5);  chk("man_ce_c5", int'(ce_w[0]), 0);
    at(6);  chk("man_ce_c6", int'(ce_w[0]), 1);
    at(10); chk("b_rdy_c10", int'(rdy_w[1]), 1); sel_valid = 1'b1; sel_mode = 2'd3;
    at(11); chk("b_err_c11", int'(err_w[1]), 1); sel_valid = 1'b0;
    at(12); chk("b_err_c12", int'(err_w[1]), 0); chk("b_mode_c12", int'(mode_w[1]), 2);
            chk("b_rdy_c12", int'(rdy_w[1]), 1); chk("a_mode_c12", int'(mode_w[0]), 3);
    at(20);

    // auto_en drops while a switch is pending.
    do_reset(1'b1);
    at(17); auto_en = 1'b0;
    at(20); chk("fall_mode", int'(mode_w[0]), 1); chk("fall_chg", int'(chg_w[0]), 1);
    at(20 + 3 * DWELL + 2); chk("fall_hold", int'(mode_w[0]), 1);

    // Async reset with a pending switch, then silence until a new request.
    do_reset(1'b0);
    at(1);  sel_valid = 1'b1; sel_mode = 2'd3;
    at(2);  sel_valid = 1'b0;
    at(4);  chk("pre_mode", int'(mode_w[0]), 3);
    at(10); sel_valid = 1'b1; sel_mode = 2'd0;
    at(11); sel_valid = 1'b0;
    chk("pre_ce", int'(ce_w[0]), 1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mode", int'(mode_w[0]), 0);
    chk("rst_ce", int'(ce_w[0]), 0);
    #10;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chg_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      at(i);
      if (chg_w[0]) chg_cnt++;
    end
    chk("rst_no_chg", chg_cnt, 0);

    // Randomised traffic against the model.
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 1; i <= 3000; i++) begin
      at(i);
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if (!(sel_valid && !rdy_w[0])) begin
        sel_valid = ($urandom_range(0, 3) == 0);
        sel_mode  = 2'($urandom_range(0, 3));
      end
    end
    sel_valid = 1'b0;
    at(3002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
